mmu_long_arbiter: RTL and testbench

// - Shares one mmu_long instance between NUM_REQ requesters using round-robin arbitration.
// - Sequences the MMU enable protocol: enable is held through data_ready, then dropped for at least 2 cycles.
// - Captures the finished product matrix into a result register and returns it with a one-hot done pulse.
// - Sits between the layer/tile sequencers and the single mmu_long datapath.

---
 rtl/mmu_long_arbiter_pkg.sv | 22 ++
 rtl/mmu_long_arbiter_if.sv | 42 ++++
 rtl/mmu_long_arbiter_rr_arbiter.sv | 35 +++
 rtl/mmu_long_arbiter.sv | 123 ++++++++++++
 tb/tb_mmu_long_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mmu_long_arbiter_pkg.sv
// Shared types and helpers for the mmu_long arbiter.
//   mmu_arb_state_e : arbiter FSM states
//   mmu_k()         : RUN cycles a full product needs (rows_a * cols_a * cols_b)
//   idx_w()         : index width for an N-way requester set, never zero
package mmu_long_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } mmu_arb_state_e;

    function automatic int unsigned mmu_k(input int unsigned rows_a, input int unsigned cols_a,
                                          input int unsigned cols_b);
        return rows_a * cols_a * cols_b;
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmu_long_arbiter_if.sv
// Requester-side and MMU-side signals of the mmu_long arbiter.
//   req/req_mat1/req_mat2/req_accum : requester level requests and operands
//   grant/done/res_mat/err_timeout  : arbiter results back to requesters
//   mmu_enable/mmu_mat_*            : drive to the shared mmu_long
//   mmu_data_ready/mmu_mat_out      : status and product from mmu_long
// slave = the arbiter, master = requesters plus the MMU.
interface mmu_long_arbiter_if #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned NUM_ROWS_A = 1,
    parameter int unsigned NUM_COLS_A = 1,
    parameter int unsigned NUM_COLS_B = 1,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [NUM_REQ-1:0]                                                 req;
    logic [NUM_REQ-1:0][NUM_ROWS_A-1:0][NUM_COLS_A-1:0][DATA_WIDTH-1:0] req_mat1;
    logic [NUM_REQ-1:0][NUM_COLS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] req_mat2;
    logic [NUM_REQ-1:0][NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] req_accum;

    logic [NUM_REQ-1:0]                                  grant;
    logic [NUM_REQ-1:0]                                  done;
    logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] res_mat;
    logic                                                err_timeout;

    logic                                                mmu_enable;
    logic [NUM_ROWS_A-1:0][NUM_COLS_A-1:0][DATA_WIDTH-1:0] mmu_mat_in1;
    logic [NUM_COLS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mmu_mat_in2;
    logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mmu_mat_accum;
    logic                                                mmu_data_ready;
    logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] mmu_mat_out;

    modport slave (
        input  req, req_mat1, req_mat2, req_accum, mmu_data_ready, mmu_mat_out,
        output grant, done, res_mat, err_timeout, mmu_enable, mmu_mat_in1, mmu_mat_in2,
               mmu_mat_accum
    );

    modport master (
        output req, req_mat1, req_mat2, req_accum, mmu_data_ready, mmu_mat_out,
        input  grant, done, res_mat, err_timeout, mmu_enable, mmu_mat_in1, mmu_mat_in2,
               mmu_mat_accum
    );
endinterface

// File: rtl/mmu_long_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req_i : request vector
//   ptr_i : highest-priority index this round
//   gnt_o : one-hot winner (zero if no request)
//   idx_o : binary index of the winner
module rr_arbiter
    import mmu_long_arbiter_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]        req_i,
    input  logic [idx_w(N)-1:0] ptr_i,
    output logic [N-1:0]        gnt_o,
    output logic [idx_w(N)-1:0] idx_o
);
    localparam int unsigned IdxW = idx_w(N);

    always_comb begin : p_scan
        logic            found;
        logic [IdxW-1:0] cand;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        // Walk from ptr_i upward with wrap; the first set request wins.
        for (int unsigned i = 0; i < N; i++) begin
            cand = IdxW'((32'(ptr_i) + i) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end
endmodule

// File: rtl/mmu_long_arbiter.sv
// Shares one mmu_long between NUM_REQ requesters (round robin).
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset, shared with the MMU
//   bus_io : requester + MMU signals (slave side)
// Job flow: IDLE (arbitrate) -> RUN (enable held until data_ready) -> DRAIN (capture
// product, pulse done) -> IDLE. mmu_enable is low for DRAIN and IDLE between jobs.
module mmu_long_arbiter
    import mmu_long_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned NUM_ROWS_A = 1,
    parameter int unsigned NUM_COLS_A = 1,
    parameter int unsigned NUM_COLS_B = 1,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIXED_PNT  = 8,
    parameter int unsigned TIMEOUT    = mmu_k(NUM_ROWS_A, NUM_COLS_A, NUM_COLS_B) + 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mmu_long_arbiter_if.slave    bus_io
);
    localparam int unsigned IdxW = idx_w(NUM_REQ);
    localparam int unsigned WdW  = $clog2(TIMEOUT + 1);

    // Fraction bits only matter to the MMU; just guard against a nonsense setting.
    if (FIXED_PNT >= DATA_WIDTH) begin : g_fp_check
        $error("FIXED_PNT must be smaller than DATA_WIDTH");
    end

    mmu_arb_state_e state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [IdxW-1:0]    gidx_q, gidx_d;
    logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WdW-1:0]     wdog_q, wdog_d;
    logic               err_q, err_d;
    logic [NUM_ROWS_A-1:0][NUM_COLS_B-1:0][DATA_WIDTH-1:0] res_q, res_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IdxW-1:0]    arb_idx;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .req_i (bus_io.req),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        gidx_d            = gidx_q;
        rr_ptr_d          = rr_ptr_q;
        wdog_d            = wdog_q;
        err_d             = err_q;
        res_d             = res_q;
        done_d            = '0;
        bus_io.mmu_enable = 1'b0;
        unique case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (|bus_io.req) begin
                    grant_d = arb_gnt;
                    gidx_d  = arb_idx;
                    state_d = RUN;
                end
            end
            RUN: begin
                bus_io.mmu_enable = 1'b1;
                // Saturating watchdog; a timeout only flags, the job keeps running.
                wdog_d = (wdog_q == WdW'(TIMEOUT)) ? wdog_q : wdog_q + WdW'(1);
                if (wdog_d == WdW'(TIMEOUT)) begin
                    err_d = 1'b1;
                end
                if (bus_io.mmu_data_ready) begin
                    state_d  = DRAIN;
                    rr_ptr_d = (gidx_q == IdxW'(NUM_REQ - 1)) ? '0 : gidx_q + IdxW'(1);
                end
            end
            DRAIN: begin
                res_d   = bus_io.mmu_mat_out;
                done_d  = grant_q;
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            wdog_q   <= wdog_d;
            err_q    <= err_d;
            res_q    <= res_d;
        end
    end

    // Operands follow the registered grant through RUN and DRAIN; zero while idle.
    assign bus_io.mmu_mat_in1   = (state_q == IDLE) ? '0 : bus_io.req_mat1[gidx_q];
    assign bus_io.mmu_mat_in2   = (state_q == IDLE) ? '0 : bus_io.req_mat2[gidx_q];
    assign bus_io.mmu_mat_accum = (state_q == IDLE) ? '0 : bus_io.req_accum[gidx_q];

    assign bus_io.grant       = grant_q;
    assign bus_io.done        = done_q;
    assign bus_io.res_mat     = res_q;
    assign bus_io.err_timeout = err_q;
endmodule

// File: tb/tb_mmu_long_arbiter.sv
// Directed bench for mmu_long_arbiter (2x2x2, DW=16, FP=8, two requesters) with a small
// behavioural mmu_long model: data_ready in the 8th enabled cycle, product registered.
module tb_mmu_long_arbiter;
    localparam int K  = 8;
    localparam int FP = 8;

    typedef logic [1:0][1:0][15:0] mat_t;

    // Requester 0: identity(1.0) x all 2.0 + 0.5 -> all 0x0280
    localparam logic [63:0] A0 = 64'h0100_0000_0000_0100;
    localparam logic [63:0] B0 = 64'h0200_0200_0200_0200;
    localparam logic [63:0] C0 = 64'h0080_0080_0080_0080;
    localparam logic [63:0] R0 = 64'h0280_0280_0280_0280;
    // Requester 1: diag(2.0) x all 1.0 + 0x0010 -> all 0x0210
    localparam logic [63:0] A1 = 64'h0200_0000_0000_0200;
    localparam logic [63:0] B1 = 64'h0100_0100_0100_0100;
    localparam logic [63:0] C1 = 64'h0010_0010_0010_0010;
    localparam logic [63:0] R1 = 64'h0210_0210_0210_0210;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stub = 1'b0;
    int   cnt;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    mmu_long_arbiter_if #(
        .NUM_REQ    (2),
        .NUM_ROWS_A (2),
        .NUM_COLS_A (2),
        .NUM_COLS_B (2),
        .DATA_WIDTH (16)
    ) bus ();

    mmu_long_arbiter #(
        .NUM_REQ    (2),
        .NUM_ROWS_A (2),
        .NUM_COLS_A (2),
        .NUM_COLS_B (2),
        .DATA_WIDTH (16),
        .FIXED_PNT  (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus.slave)
    );

    function automatic mat_t mmu_calc(input mat_t a, input mat_t b, input mat_t c);
        mat_t r;
        int   acc;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                acc = 0;
                for (int k = 0; k < 2; k++) begin
                    acc += int'($signed(a[i][k])) * int'($signed(b[k][j]));
                end
                r[i][j] = 16'((acc >>> FP) + int'($signed(c[i][j])));
            end
        end
        return r;
    endfunction

    // MMU model: product appears on mat_out the edge after the last enabled cycle.
    assign bus.mmu_data_ready = bus.mmu_enable && (cnt == K - 1) && !stub;
    always @(posedge clk) begin
        if (!rst_n) begin
            cnt             <= 0;
            bus.mmu_mat_out <= '0;
        end else begin
            cnt <= bus.mmu_enable ? cnt + 1 : 0;
            if (bus.mmu_enable) begin
                bus.mmu_mat_out <= mmu_calc(bus.mmu_mat_in1, bus.mmu_mat_in2,
                                            bus.mmu_mat_accum);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Ticks until done pulses (bounded). en counts enable-high samples before done,
    // including the sample taken on entry.
    task automatic wait_done(output logic [1:0] d, output int cyc, output int en);
        d   = 2'b00;
        cyc = 0;
        en  = int'(bus.mmu_enable);
        while (cyc < 40) begin
            tick();
            cyc++;
            if (bus.done != 2'b00) begin
                d = bus.done;
                break;
            end
            en += int'(bus.mmu_enable);
        end
    endtask

    initial begin
        logic [1:0] d;
        int         cyc;
        int         en;

        bus.req         = '0;
        bus.req_mat1[0] = A0;
        bus.req_mat2[0] = B0;
        bus.req_accum[0] = C0;
        bus.req_mat1[1] = A1;
        bus.req_mat2[1] = B1;
        bus.req_accum[1] = C1;

        // Reset state
        tick();
        tick();
        check("rst_grant", bus.grant, 0);
        check("rst_done", bus.done, 0);
        check("rst_res", bus.res_mat, 0);
        check("rst_err", bus.err_timeout, 0);
        check("rst_en", bus.mmu_enable, 0);
        check("rst_in1", bus.mmu_mat_in1, 0);
        rst_n = 1'b1;

        // 1: single job on requester 0
        bus.req = 2'b01;
        tick();
        check("t1_grant", bus.grant, 2'b01);
        check("t1_in1", bus.mmu_mat_in1, A0);
        wait_done(d, cyc, en);
        check("t1_done", d, 2'b01);
        check("t1_latency", cyc, 9);
        check("t1_en_cycles", en, 8);
        check("t1_res", bus.res_mat, R0);
        check("t1_grant_off", bus.grant, 0);
        bus.req = 2'b00;
        tick();
        check("t1_pulse", bus.done, 0);
        check("t1_res_hold", bus.res_mat, R0);
        check("t1_idle_in1", bus.mmu_mat_in1, 0);

        // 2: both request at once after reset
        do_reset();
        bus.req = 2'b11;
        tick();
        check("t2_grant0", bus.grant, 2'b01);
        wait_done(d, cyc, en);
        check("t2_done0", d, 2'b01);
        check("t2_en0", en, 8);
        check("t2_res0", bus.res_mat, R0);
        check("t2_gap_idle", bus.mmu_enable, 0);
        bus.req = 2'b10;
        tick();
        check("t2_grant1", bus.grant, 2'b10);
        check("t2_gap_end", bus.mmu_enable, 1);
        check("t2_in1", bus.mmu_mat_in1, A1);
        wait_done(d, cyc, en);
        check("t2_done1", d, 2'b10);
        check("t2_en1", en, 8);
        check("t2_res1", bus.res_mat, R1);
        bus.req = 2'b00;

        // 3: both held for six jobs -> strict alternation
        bus.req = 2'b11;
        for (int j = 0; j < 6; j++) begin
            wait_done(d, cyc, en);
            check($sformatf("t3_done%0d", j), d, (j % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("t3_res%0d", j), bus.res_mat, (j % 2 == 0) ? R0 : R1);
        end
        bus.req = 2'b00;
        check("t3_err", bus.err_timeout, 0);
        tick();

        // 4: reset during RUN cycle 4 of requester 0
        bus.req = 2'b01;
        tick();
        tick();
        tick();
        tick();
        check("t4_running", bus.mmu_enable, 1);
        rst_n   = 1'b0;
        bus.req = 2'b00;
        tick();
        check("t4_grant", bus.grant, 0);
        check("t4_en", bus.mmu_enable, 0);
        check("t4_res", bus.res_mat, 0);
        check("t4_in1", bus.mmu_mat_in1, 0);
        rst_n = 1'b1;
        tick();
        check("t4_no_done", bus.done, 0);
        bus.req = 2'b01;
        tick();
        wait_done(d, cyc, en);
        check("t4_redo_done", d, 2'b01);
        check("t4_redo_res", bus.res_mat, R0);
        bus.req = 2'b00;
        tick();

        // 5: requester 0 drops mid-job, requester 1 pending
        do_reset();
        bus.req = 2'b01;
        tick();
        tick();
        tick();
        bus.req = 2'b10;
        wait_done(d, cyc, en);
        check("t5_done0", d, 2'b01);
        check("t5_res0", bus.res_mat, R0);
        tick();
        check("t5_grant1", bus.grant, 2'b10);
        wait_done(d, cyc, en);
        check("t5_done1", d, 2'b10);
        check("t5_res1", bus.res_mat, R1);
        bus.req = 2'b00;
        tick();

        // 6: MMU never finishes -> sticky timeout after 12 RUN cycles
        stub = 1'b1;
        do_reset();
        bus.req = 2'b01;
        tick();
        for (int i = 0; i < 11; i++) tick();
        check("t6_err_early", bus.err_timeout, 0);
        tick();
        check("t6_err_set", bus.err_timeout, 1);
        check("t6_still_run", bus.mmu_enable, 1);
        for (int i = 0; i < 5; i++) tick();
        check("t6_err_sticky", bus.err_timeout, 1);
        check("t6_grant_held", bus.grant, 2'b01);
        bus.req = 2'b00;
        do_reset();
        check("t6_err_clr", bus.err_timeout, 0);
        stub = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
